// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment text display: ASCII codes and
// active-low segment patterns (bit 7 = dp, always off in these codes).
package seg7_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_DIGITS [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // One approximated glyph per letter, upper and lower case share an entry.
    localparam logic [7:0] SEG_LETTERS [26] = '{
        8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h89, 8'hCF,  // A..I
        8'hE1, 8'h8A, 8'hC7, 8'hEA, 8'hAB, 8'hA3, 8'h8C, 8'h98, 8'hAF,  // J..R
        8'h92, 8'h87, 8'hC1, 8'hE3, 8'hD5, 8'h89, 8'h91, 8'hA4          // S..Z
    };

endpackage

// File: rtl/seg7_text_scroller_if.sv
// Character input and display output bundle of the seven-segment text scroller.
interface seg7_text_scroller_if #(
    parameter int unsigned N_DIGITS = 4
);

    logic [7:0]          char_in;
    logic                char_valid;
    logic                clear;
    logic                scroll_en;
    logic [N_DIGITS-1:0] dp_in;
    logic [N_DIGITS-1:0] an;
    logic [7:0]          seg;

    modport master (
        output char_in, char_valid, clear, scroll_en, dp_in,
        input  an, seg
    );

    modport slave (
        input  char_in, char_valid, clear, scroll_en, dp_in,
        output an, seg
    );

endinterface

// File: rtl/ascii_to_seg7.sv
// Combinational ASCII to active-low seven-segment decoder (no dp bit).
module ascii_to_seg7
    import seg7_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [6:0] seg
);

    logic [7:0] upper;

    always_comb begin
        upper = ascii;
        if (ascii >= 8'h61 && ascii <= 8'h7A) begin
            upper = ascii - 8'h20;
        end

        seg = SEG_BLANK[6:0];
        if (upper >= 8'h30 && upper <= 8'h39) begin
            seg = SEG_DIGITS[4'(upper - 8'h30)][6:0];
        end else if (upper >= 8'h41 && upper <= 8'h5A) begin
            seg = SEG_LETTERS[5'(upper - 8'h41)][6:0];
        end else if (upper == ASCII_DASH) begin
            seg = SEG_DASH[6:0];
        end
    end

endmodule

// File: rtl/seg7_text_scroller.sv
// N-digit multiplexed seven-segment text display with a bounded character
// buffer, backspace/clear, per-digit decimal points and optional scrolling.
module seg7_text_scroller
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned BUF_DEPTH   = 16,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned SCROLL_DIV  = 25000000
) (
    input logic                 clk,
    input logic                 reset,
    seg7_text_scroller_if.slave bus
);

    localparam int unsigned LenW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned DigW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned ScrW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [7:0]          char_buf_q [BUF_DEPTH];
    logic [7:0]          char_buf_d [BUF_DEPTH];
    logic [LenW-1:0]     len_q, len_d;
    logic [LenW-1:0]     offset_q, offset_d;
    logic [ScrW-1:0]     scroll_cnt_q, scroll_cnt_d;
    logic [RefW-1:0]     refresh_cnt_q, refresh_cnt_d;
    logic [DigW-1:0]     digit_q, digit_d;
    logic                scroll_en_q;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          seg_q, seg_d;

    logic            buf_change;
    logic            scroll_active;
    logic [LenW-1:0] digit_l;
    logic [LenW-1:0] sel_idx;
    logic [7:0]      sel_char;
    logic [6:0]      glyph;

    // Buffer write / backspace / clear; clear wins over a strobe in the same cycle.
    always_comb begin
        char_buf_d = char_buf_q;
        len_d      = len_q;
        buf_change = 1'b0;
        if (bus.clear) begin
            len_d      = '0;
            buf_change = 1'b1;
        end else if (bus.char_valid) begin
            if (bus.char_in == ASCII_BS) begin
                if (len_q != '0) begin
                    len_d      = len_q - LenW'(1);
                    buf_change = 1'b1;
                end
            end else if (len_q < LenW'(BUF_DEPTH)) begin
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    if (LenW'(i) == len_q) begin
                        char_buf_d[i] = bus.char_in;
                    end
                end
                len_d      = len_q + LenW'(1);
                buf_change = 1'b1;
            end else begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                    char_buf_d[i] = char_buf_q[i+1];
                end
                char_buf_d[BUF_DEPTH-1] = bus.char_in;
                buf_change              = 1'b1;
            end
        end
    end

    // Character for the digit currently being scanned.
    always_comb begin
        scroll_active = bus.scroll_en && (len_q > LenW'(N_DIGITS));
        digit_l       = LenW'(digit_q);
        if (scroll_active) begin
            sel_idx = offset_q + LenW'(N_DIGITS - 1) - digit_l;
        end else begin
            sel_idx = len_q - LenW'(1) - digit_l;
        end
        sel_char = ASCII_SPACE;
        if (scroll_active || (digit_l < len_q)) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (LenW'(i) == sel_idx) begin
                    sel_char = char_buf_q[i];
                end
            end
        end
    end

    ascii_to_seg7 u_decode (
        .ascii (sel_char),
        .seg   (glyph)
    );

    // Scroll window and scan timing.
    always_comb begin
        offset_d     = offset_q;
        scroll_cnt_d = scroll_cnt_q;
        if (buf_change || (bus.scroll_en != scroll_en_q) || !scroll_active) begin
            offset_d     = '0;
            scroll_cnt_d = '0;
        end else if (scroll_cnt_q == ScrW'(SCROLL_DIV - 1)) begin
            scroll_cnt_d = '0;
            offset_d     = (offset_q == len_q - LenW'(N_DIGITS)) ? '0 : offset_q + LenW'(1);
        end else begin
            scroll_cnt_d = scroll_cnt_q + ScrW'(1);
        end

        refresh_cnt_d = refresh_cnt_q + RefW'(1);
        digit_d       = digit_q;
        if (refresh_cnt_q == RefW'(REFRESH_DIV - 1)) begin
            refresh_cnt_d = '0;
            digit_d       = (digit_q == DigW'(N_DIGITS - 1)) ? '0 : digit_q + DigW'(1);
        end

        // an and seg come from the same index so they switch together.
        for (int i = 0; i < N_DIGITS; i++) begin
            an_d[i] = (DigW'(i) != digit_q);
        end
        seg_d = {~bus.dp_in[digit_q], glyph};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q         <= '0;
            offset_q      <= '0;
            scroll_cnt_q  <= '0;
            refresh_cnt_q <= '0;
            digit_q       <= '0;
            scroll_en_q   <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
        end else begin
            len_q         <= len_d;
            offset_q      <= offset_d;
            scroll_cnt_q  <= scroll_cnt_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_q       <= digit_d;
            scroll_en_q   <= bus.scroll_en;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    // Contents are only meaningful below len_q, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        char_buf_q <= char_buf_d;
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg7_text_scroller.sv
// Scoreboard bench for seg7_text_scroller: expected per-digit segments are queued
// by the stimulus and checked by a monitor at each digit switch.
module tb_seg7_text_scroller;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [3:0] exp_an_q  [$];
    logic [7:0] exp_seg_q [$];
    string      exp_name_q[$];

    seg7_text_scroller_if #(.N_DIGITS(4)) bus ();

    seg7_text_scroller #(
        .N_DIGITS    (4),
        .BUF_DEPTH   (8),
        .REFRESH_DIV (4),
        .SCROLL_DIV  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] c);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        tick(1);
        bus.char_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
    endtask

    task automatic push(input string name, input logic [3:0] an, input logic [7:0] seg);
        exp_an_q.push_back(an);
        exp_seg_q.push_back(seg);
        exp_name_q.push_back(name);
    endtask

    // Returns just after an has switched to digit 0.
    task automatic sync_frame();
        int n = 0;
        while (bus.an !== 4'b0111 && n < 40) begin
            tick(1);
            n++;
        end
        while (bus.an !== 4'b1110 && n < 40) begin
            tick(1);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL sync: an=%b never reached digit 0", bus.an);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_an_q.size() != 0 && n < 80) begin
            tick(1);
            n++;
        end
        if (exp_an_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: digit an=%b never shown, got an=%b", exp_name_q[0], exp_an_q[0],
                     bus.an);
            exp_an_q.delete();
            exp_seg_q.delete();
            exp_name_q.delete();
        end
    endtask

    task automatic expect_frame(input string name, input logic [7:0] s3, input logic [7:0] s2,
                                input logic [7:0] s1, input logic [7:0] s0);
        tick(2);
        sync_frame();
        push({name, " d1"}, 4'b1101, s1);
        push({name, " d2"}, 4'b1011, s2);
        push({name, " d3"}, 4'b0111, s3);
        push({name, " d0"}, 4'b1110, s0);
        drain();
    endtask

    // Monitor: a new an value is a fresh digit presentation.
    initial begin
        logic [3:0] prev_an;
        logic [7:0] want;
        string      name;
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (bus.an !== prev_an && exp_an_q.size() != 0 && exp_an_q[0] === bus.an) begin
                void'(exp_an_q.pop_front());
                want = exp_seg_q.pop_front();
                name = exp_name_q.pop_front();
                check(name, bus.seg, want);
            end
            prev_an = bus.an;
        end
    end

    initial begin
        logic [3:0] one;
        logic [3:0] exp_an;
        one            = 4'b0001;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        bus.clear      = 1'b0;
        bus.scroll_en  = 1'b0;
        bus.dp_in      = 4'b0000;

        // Reset state and scan order with an empty buffer.
        tick(3);
        check("reset an", {4'h0, bus.an}, 8'h0F);
        check("reset seg", bus.seg, 8'hFF);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            exp_an = ~(one << (i / 4));
            check("scan an", {4'h0, bus.an}, {4'h0, exp_an});
            check("scan seg", bus.seg, 8'hFF);
        end

        // Two characters, newest on the right.
        strobe(8'h31);
        strobe(8'h30);
        expect_frame("two chars", 8'hFF, 8'hFF, 8'hF9, 8'hC0);

        // Overflow drops the oldest character.
        do_clear();
        for (int i = 0; i < 9; i++) strobe(8'(8'h30 + i));
        expect_frame("overflow", 8'h92, 8'h82, 8'hF8, 8'h80);

        // Scroll across "012345": windows 0123, 1234, 2345, then wrap.
        do_clear();
        for (int i = 0; i < 6; i++) strobe(8'(8'h30 + i));
        tick(2);
        sync_frame();
        bus.scroll_en = 1'b1;
        push("scroll w0 d1", 4'b1101, 8'hA4);
        push("scroll w0 d2", 4'b1011, 8'hF9);
        push("scroll w1 d3", 4'b0111, 8'hF9);
        push("scroll w1 d0", 4'b1110, 8'h99);
        push("scroll w2 d1", 4'b1101, 8'h99);
        push("scroll w2 d2", 4'b1011, 8'hB0);
        push("scroll wrap d3", 4'b0111, 8'hC0);
        push("scroll wrap d0", 4'b1110, 8'hB0);
        drain();
        bus.scroll_en = 1'b0;

        // Clear beats a simultaneous strobe; letters; backspace.
        bus.clear      = 1'b1;
        bus.char_in    = 8'h41;
        bus.char_valid = 1'b1;
        tick(1);
        bus.clear      = 1'b0;
        bus.char_valid = 1'b0;
        expect_frame("clear prio", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        strobe(8'h41);
        expect_frame("letter A", 8'hFF, 8'hFF, 8'hFF, 8'h88);
        strobe(8'h08);
        expect_frame("backspace", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        strobe(8'h08);
        strobe(8'h2D);
        strobe(8'h62);
        expect_frame("bs empty dash b", 8'hFF, 8'hFF, 8'hBF, 8'h83);

        // Decimal point on digit 2 only, empty buffer.
        do_clear();
        bus.dp_in = 4'b0100;
        expect_frame("dp", 8'hFF, 8'h7F, 8'hFF, 8'hFF);
        bus.dp_in = 4'b0000;

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
